// File: rtl/alu_issue_ctrl_pkg.sv
// Shared word/opcode sizing, controller state type and ALU opcode encodings
// for the 19-bit datapath.
package constants;
   localparam int WORD_SIZE   = 19;
   localparam int OPCODE_SIZE = 4;

   typedef enum logic [1:0] {IDLE, READ, EXEC, WB} alu_issue_state_t;
endpackage

package opcodes;
   import constants::*;

   localparam logic [OPCODE_SIZE-1:0] ADD = 4'd0;
   localparam logic [OPCODE_SIZE-1:0] SUB = 4'd1;
   localparam logic [OPCODE_SIZE-1:0] MUL = 4'd2;
   localparam logic [OPCODE_SIZE-1:0] DIV = 4'd3;
   localparam logic [OPCODE_SIZE-1:0] INC = 4'd4;
   localparam logic [OPCODE_SIZE-1:0] DEC = 4'd5;
   localparam logic [OPCODE_SIZE-1:0] AND = 4'd6;
   localparam logic [OPCODE_SIZE-1:0] OR  = 4'd7;
   localparam logic [OPCODE_SIZE-1:0] XOR = 4'd8;
   localparam logic [OPCODE_SIZE-1:0] NOT = 4'd9;

   // Encodings above NOT are unassigned.
   function automatic logic is_legal_op(input logic [OPCODE_SIZE-1:0] op);
      return op <= NOT;
   endfunction

   function automatic logic is_unary_op(input logic [OPCODE_SIZE-1:0] op);
      return (op == INC) || (op == DEC) || (op == NOT);
   endfunction
endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Bundle of the decoder handshake, register-file ports and ALU drive/result
// signals around the ALU issue controller.
interface alu_issue_ctrl_if #(
   parameter int REG_ADDR_W = 3
);
   import constants::*;

   logic                   instr_valid;
   logic                   instr_ready;
   logic [OPCODE_SIZE-1:0] instr_op;
   logic [REG_ADDR_W-1:0]  instr_rd;
   logic [REG_ADDR_W-1:0]  instr_rs1;
   logic [REG_ADDR_W-1:0]  instr_rs2;
   logic [REG_ADDR_W-1:0]  rf_raddr1;
   logic [REG_ADDR_W-1:0]  rf_raddr2;
   logic [WORD_SIZE-1:0]   rf_rdata1;
   logic [WORD_SIZE-1:0]   rf_rdata2;
   logic                   rf_we;
   logic [REG_ADDR_W-1:0]  rf_waddr;
   logic [WORD_SIZE-1:0]   rf_wdata;
   logic [OPCODE_SIZE-1:0] alu_op;
   logic [WORD_SIZE-1:0]   alu_a;
   logic [WORD_SIZE-1:0]   alu_b;
   logic [WORD_SIZE-1:0]   alu_result;
   logic                   done;
   logic                   illegal;
   logic                   div_zero;

   // Decoder, register file and ALU side.
   modport master (
      output instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2,
             rf_rdata1, rf_rdata2, alu_result,
      input  instr_ready, rf_raddr1, rf_raddr2, rf_we, rf_waddr, rf_wdata,
             alu_op, alu_a, alu_b, done, illegal, div_zero
   );

   // Issue controller side.
   modport slave (
      input  instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2,
             rf_rdata1, rf_rdata2, alu_result,
      output instr_ready, rf_raddr1, rf_raddr2, rf_we, rf_waddr, rf_wdata,
             alu_op, alu_a, alu_b, done, illegal, div_zero
   );
endinterface

// File: rtl/alu_issue_ctrl_op_decode.sv
// Combinational opcode classifier used during the register-read cycle.
module alu_op_decode
   import constants::*;
   import opcodes::*;
(
   input  logic [OPCODE_SIZE-1:0] op_i,
   output logic                   legal_o,
   output logic                   unary_o,
   output logic                   is_div_o
);

   assign legal_o  = is_legal_op(op_i);
   assign unary_o  = is_unary_op(op_i);
   assign is_div_o = (op_i == DIV);

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues one ALU instruction at a time: register read, ALU drive for
// ALU_LATENCY cycles, write-back. ALU_ISSUE_DIVZERO_CHECK_EN enables DIV-by-zero trapping.
module alu_issue_ctrl
   import constants::*;
   import opcodes::*;
#(
   parameter int REG_ADDR_W  = 3,
   parameter int ALU_LATENCY = 1
) (
   input  logic           clk,
   input  logic           rst_n,
   alu_issue_ctrl_if.slave bus
);

   localparam int               CNT_W    = 2;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ALU_LATENCY - 1);

   alu_issue_state_t       state_q, state_d;
   logic [OPCODE_SIZE-1:0] op_q, alu_op_q;
   logic [REG_ADDR_W-1:0]  rd_q, rs1_q, rs2_q;
   logic [WORD_SIZE-1:0]   alu_a_q, alu_b_q, result_q;
   logic [CNT_W-1:0]       cnt_q;
   logic                   ready_q, illegal_q, div_zero_q;
   logic                   legal, unary, is_div, div_zero_hit, accept, wb_write;

   alu_op_decode u_op_decode (
      .op_i     (op_q),
      .legal_o  (legal),
      .unary_o  (unary),
      .is_div_o (is_div)
   );

`ifdef ALU_ISSUE_DIVZERO_CHECK_EN
   assign div_zero_hit = is_div && (bus.rf_rdata2 == '0);
`else
   assign div_zero_hit = is_div & 1'b0;
`endif

   assign accept      = (state_q == IDLE) && ready_q && bus.instr_valid;
   assign wb_write    = !(illegal_q || div_zero_q);
   assign bus.alu_op  = alu_op_q;
   assign bus.alu_a   = alu_a_q;
   assign bus.alu_b   = alu_b_q;

   always_comb begin
      // NOTE: every output and the next state get a default first so no path infers a latch.
      state_d         = state_q;
      bus.instr_ready = ready_q;
      bus.rf_raddr1   = '0;
      bus.rf_raddr2   = '0;
      bus.rf_we       = 1'b0;
      bus.rf_waddr    = '0;
      bus.rf_wdata    = '0;
      bus.done        = 1'b0;
      bus.illegal     = 1'b0;
      bus.div_zero    = 1'b0;
      unique case (state_q)
         IDLE: if (accept) state_d = READ;
         READ: begin
            bus.rf_raddr1 = rs1_q;
            bus.rf_raddr2 = rs2_q;
            state_d       = (!legal || div_zero_hit) ? WB : EXEC;
         end
         EXEC: if (cnt_q == '0) state_d = WB;
         WB: begin
            bus.rf_we    = wb_write;
            bus.rf_waddr = wb_write ? rd_q : '0;
            bus.rf_wdata = wb_write ? result_q : '0;
            bus.done     = 1'b1;
            bus.illegal  = illegal_q;
            bus.div_zero = div_zero_q;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      // NOTE: datapath registers are reset too, because every output must read 0 after reset.
      if (!rst_n) begin
         state_q    <= IDLE;
         ready_q    <= 1'b0;
         op_q       <= '0;
         rd_q       <= '0;
         rs1_q      <= '0;
         rs2_q      <= '0;
         alu_op_q   <= '0;
         alu_a_q    <= '0;
         alu_b_q    <= '0;
         result_q   <= '0;
         cnt_q      <= '0;
         illegal_q  <= 1'b0;
         div_zero_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ready_q <= (state_d == IDLE);
         if (accept) begin
            op_q  <= bus.instr_op;
            rd_q  <= bus.instr_rd;
            rs1_q <= bus.instr_rs1;
            rs2_q <= bus.instr_rs2;
         end
         if (state_q == READ) begin
            illegal_q  <= !legal;
            div_zero_q <= legal && div_zero_hit;
            // ALU drive registers only change on EXEC entry and hold otherwise.
            if (state_d == EXEC) begin
               alu_op_q <= op_q;
               alu_a_q  <= bus.rf_rdata1;
               alu_b_q  <= unary ? '0 : bus.rf_rdata2;
               cnt_q    <= CNT_LOAD;
            end
         end
         if (state_q == EXEC) begin
            if (cnt_q == '0) result_q <= bus.alu_result;
            else             cnt_q    <= cnt_q - 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed cases followed by random
// instructions, checked cycle by cycle against a register-file reference model.
module tb_alu_issue_ctrl;
   import constants::*;
   import opcodes::*;

   localparam int L = 1;

   typedef struct packed {
      logic [OPCODE_SIZE-1:0] op;
      logic [2:0]             rd;
      logic [2:0]             rs1;
      logic [2:0]             rs2;
   } instr_t;

   logic clk = 1'b0;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;

   logic [WORD_SIZE-1:0] env_rf [8];
   logic [WORD_SIZE-1:0] ref_rf [8];
   logic                 pre_we;
   logic [2:0]           pre_addr;
   logic [WORD_SIZE-1:0] pre_data;

   alu_issue_ctrl_if #(.REG_ADDR_W(3)) bus ();

   alu_issue_ctrl #(.REG_ADDR_W(3), .ALU_LATENCY(L)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Behaviour of the ALU being driven; a zero divisor yields all ones.
   function automatic logic [WORD_SIZE-1:0] alu_fn(input logic [OPCODE_SIZE-1:0] op,
                                                   input logic [WORD_SIZE-1:0] a,
                                                   input logic [WORD_SIZE-1:0] b);
      case (op)
         ADD:     return a + b;
         SUB:     return a - b;
         MUL:     return a * b;
         DIV:     return (b == '0) ? '1 : a / b;
         INC:     return a + 19'd1;
         DEC:     return a - 19'd1;
         AND:     return a & b;
         OR:      return a | b;
         XOR:     return a ^ b;
         NOT:     return ~a;
         default: return '0;
      endcase
   endfunction

   // Environment: register file with combinational read and the ALU.
   assign bus.rf_rdata1  = env_rf[bus.rf_raddr1];
   assign bus.rf_rdata2  = env_rf[bus.rf_raddr2];
   assign bus.alu_result = alu_fn(bus.alu_op, bus.alu_a, bus.alu_b);

   always @(posedge clk) begin
      if (bus.rf_we) env_rf[bus.rf_waddr] <= bus.rf_wdata;
      if (pre_we)    env_rf[pre_addr]     <= pre_data;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic instr_t mk(input logic [OPCODE_SIZE-1:0] op, input int rd, input int rs1,
                                 input int rs2);
      instr_t i;
      i.op  = op;
      i.rd  = 3'(rd);
      i.rs1 = 3'(rs1);
      i.rs2 = 3'(rs2);
      return i;
   endfunction

   // Called at a falling edge; returns at the next falling edge.
   task automatic set_reg(input int idx, input logic [WORD_SIZE-1:0] val);
      pre_we      = 1'b1;
      pre_addr    = 3'(idx);
      pre_data    = val;
      ref_rf[idx] = val;
      @(negedge clk);
      pre_we = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ready"},    32'(bus.instr_ready), 32'd0);
      check({tag, "_rf_we"},    32'(bus.rf_we),       32'd0);
      check({tag, "_done"},     32'(bus.done),        32'd0);
      check({tag, "_illegal"},  32'(bus.illegal),     32'd0);
      check({tag, "_div_zero"}, 32'(bus.div_zero),    32'd0);
      check({tag, "_raddr"},    32'({bus.rf_raddr1, bus.rf_raddr2}), 32'd0);
      check({tag, "_waddr"},    32'(bus.rf_waddr),    32'd0);
      check({tag, "_wdata"},    32'(bus.rf_wdata),    32'd0);
      check({tag, "_alu_op"},   32'(bus.alu_op),      32'd0);
      check({tag, "_alu_a"},    32'(bus.alu_a),       32'd0);
      check({tag, "_alu_b"},    32'(bus.alu_b),       32'd0);
   endtask

   // Called at a falling edge. Offers ins, then checks every cycle up to the
   // next cycle where an instruction can be accepted. With hold set, valid
   // stays high after acceptance and nxt is presented on the inputs.
   task automatic issue(input string tag, input instr_t ins, input bit hold, input instr_t nxt);
      logic                 legal, unary, dz, exp_we;
      logic [WORD_SIZE-1:0] a, b, res;
      int                   wb;
      int                   budget;
      budget = 0;
      while (bus.instr_ready !== 1'b1 && budget < 16) begin
         @(negedge clk);
         budget++;
      end
      check({tag, "_ready_wait"}, 32'(bus.instr_ready), 32'd1);
      bus.instr_valid = 1'b1;
      bus.instr_op    = ins.op;
      bus.instr_rd    = ins.rd;
      bus.instr_rs1   = ins.rs1;
      bus.instr_rs2   = ins.rs2;

      legal = (ins.op <= 4'd9);
      unary = (ins.op == INC) || (ins.op == DEC) || (ins.op == NOT);
      a     = ref_rf[ins.rs1];
      b     = unary ? '0 : ref_rf[ins.rs2];
`ifdef ALU_ISSUE_DIVZERO_CHECK_EN
      dz    = legal && (ins.op == DIV) && (ref_rf[ins.rs2] == '0);
`else
      dz    = 1'b0;
`endif
      exp_we = legal && !dz;
      wb     = exp_we ? 2 + L : 2;
      res    = alu_fn(ins.op, a, b);

      @(posedge clk);
      #1;
      if (hold) begin
         bus.instr_op  = nxt.op;
         bus.instr_rd  = nxt.rd;
         bus.instr_rs1 = nxt.rs1;
         bus.instr_rs2 = nxt.rs2;
      end else begin
         bus.instr_valid = 1'b0;
         bus.instr_op    = 4'($urandom);
         bus.instr_rd    = 3'($urandom);
         bus.instr_rs1   = 3'($urandom);
         bus.instr_rs2   = 3'($urandom);
      end

      for (int k = 1; k <= wb + 1; k++) begin
         @(negedge clk);
         check({tag, "_ready"},    32'(bus.instr_ready), 32'(k > wb));
         check({tag, "_done"},     32'(bus.done),        32'(k == wb));
         check({tag, "_rf_we"},    32'(bus.rf_we),       32'(k == wb && exp_we));
         check({tag, "_waddr"},    32'(bus.rf_waddr),    (k == wb && exp_we) ? 32'(ins.rd) : 32'd0);
         check({tag, "_wdata"},    32'(bus.rf_wdata),    (k == wb && exp_we) ? 32'(res) : 32'd0);
         check({tag, "_illegal"},  32'(bus.illegal),     32'(k == wb && !legal));
         check({tag, "_div_zero"}, 32'(bus.div_zero),    32'(k == wb && dz));
         check({tag, "_raddr1"},   32'(bus.rf_raddr1),   (k == 1) ? 32'(ins.rs1) : 32'd0);
         check({tag, "_raddr2"},   32'(bus.rf_raddr2),   (k == 1) ? 32'(ins.rs2) : 32'd0);
         if (exp_we && k >= 2 && k < wb) begin
            check({tag, "_alu_op"}, 32'(bus.alu_op), 32'(ins.op));
            check({tag, "_alu_a"},  32'(bus.alu_a),  32'(a));
            check({tag, "_alu_b"},  32'(bus.alu_b),  32'(b));
         end
      end
      if (exp_we) ref_rf[ins.rd] = res;
   endtask

   initial begin
      instr_t               ins;
      logic [WORD_SIZE-1:0] prev;
      rst_n           = 1'b0;
      pre_we          = 1'b0;
      pre_addr        = '0;
      pre_data        = '0;
      bus.instr_valid = 1'b0;
      bus.instr_op    = '0;
      bus.instr_rd    = '0;
      bus.instr_rs1   = '0;
      bus.instr_rs2   = '0;

      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);
      check("ready_after_reset", 32'(bus.instr_ready), 32'd1);

      for (int i = 0; i < 8; i++) set_reg(i, WORD_SIZE'(i * 3));
      set_reg(1, 19'd10);
      set_reg(2, 19'd5);
      set_reg(7, 19'd99);

      issue("add",  mk(ADD, 3, 1, 2), 1'b0, mk(ADD, 0, 0, 0));
      issue("inc",  mk(INC, 4, 1, 7), 1'b0, mk(ADD, 0, 0, 0));

      set_reg(1, 19'd20);
      set_reg(2, 19'd0);
      issue("div0", mk(DIV, 5, 1, 2), 1'b0, mk(ADD, 0, 0, 0));
      issue("ill",  mk(4'hC, 6, 1, 2), 1'b0, mk(ADD, 0, 0, 0));
      issue("ill_max", mk(4'hF, 0, 3, 4), 1'b0, mk(ADD, 0, 0, 0));

      set_reg(1, 19'd10);
      set_reg(2, 19'd5);
      issue("sub_a", mk(SUB, 3, 1, 2), 1'b1, mk(SUB, 5, 3, 2));
      issue("sub_b", mk(SUB, 5, 3, 2), 1'b0, mk(ADD, 0, 0, 0));
      check("sub_r3", 32'(ref_rf[3]), 32'd5);
      check("sub_r5", 32'(ref_rf[5]), 32'd0);

      // Reset during EXEC abandons the instruction.
      prev            = env_rf[6];
      check("rst_ready", 32'(bus.instr_ready), 32'd1);
      bus.instr_valid = 1'b1;
      bus.instr_op    = AND;
      bus.instr_rd    = 3'd6;
      bus.instr_rs1   = 3'd1;
      bus.instr_rs2   = 3'd2;
      @(posedge clk);
      #1 bus.instr_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("rst_exec_op", 32'(bus.alu_op), 32'(AND));
      rst_n = 1'b0;
      @(negedge clk);
      check_all_zero("rst_mid");
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_ready_back", 32'(bus.instr_ready), 32'd1);
      check("rst_no_done",    32'(bus.done),        32'd0);
      check("rst_no_write",   32'(env_rf[6]),       32'(prev));

      for (int i = 0; i < 8; i++) set_reg(i, WORD_SIZE'($urandom));
      set_reg(0, '0);
      for (int n = 0; n < 40; n++) begin
         ins.op  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                : 4'($urandom_range(0, 9));
         ins.rd  = 3'($urandom);
         ins.rs1 = 3'($urandom);
         ins.rs2 = ($urandom_range(0, 3) == 0) ? 3'd0 : 3'($urandom);
         issue("rand", ins, 1'b0, ins);
      end

      for (int i = 0; i < 8; i++) check("final_rf", 32'(env_rf[i]), 32'(ref_rf[i]));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
